// File: rtl/lcd_frame_pkg.sv
// Shared definitions for the LCD output stage: run/stop FSM states and the
// default raster timing that the filter pipe windows are built from.
package lcd_frame_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } frame_state_t;

    localparam int H_TOTAL_DEF   = 1056;
    localparam int H_SYNC_W_DEF  = 30;
    localparam int H_START_DEF   = 216;
    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_TOTAL_DEF   = 525;
    localparam int V_SYNC_W_DEF  = 3;
    localparam int V_START_DEF   = 35;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int READ_LEAD_DEF = 2;

    function automatic logic in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/lcd_raster_counter.sv
// Half-rate pixel enable plus free-running H/V raster counters with wrap flags.
module lcd_raster_counter
    import lcd_frame_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic        Clock,
    input  logic        Resetn,
    output logic        clock_en,
    output logic [10:0] h_count,
    output logic [9:0]  v_count,
    output logic        end_of_line,
    output logic        end_of_frame
);

    assign end_of_line  = clock_en && (h_count == 11'(H_TOTAL - 1));
    // High for the whole last line; qualify with end_of_line for the wrap point.
    assign end_of_frame = (v_count == 10'(V_TOTAL - 1));

    // NOTE: state is updated with <= so every reader in this edge sees the old value.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            clock_en <= 1'b0;
            h_count  <= '0;
            v_count  <= '0;
        end else begin
            clock_en <= !clock_en;
            if (end_of_line) begin
                h_count <= '0;
                v_count <= end_of_frame ? 10'd0 : v_count + 10'd1;
            end else if (clock_en) begin
                h_count <= h_count + 11'd1;
            end
        end
    end

endmodule

// File: rtl/lcd_frame_out.sv
// LCD raster timing and panel driver for the image filter pipe, with a
// start/stop FSM that only switches streaming at frame boundaries.
module lcd_frame_out
    import lcd_frame_pkg::*;
#(
    parameter int H_TOTAL   = H_TOTAL_DEF,
    parameter int H_SYNC_W  = H_SYNC_W_DEF,
    parameter int H_START   = H_START_DEF,
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_TOTAL   = V_TOTAL_DEF,
    parameter int V_SYNC_W  = V_SYNC_W_DEF,
    parameter int V_START   = V_START_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int READ_LEAD = READ_LEAD_DEF
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic        Clock_en,
    output logic [10:0] H_Count,
    output logic [9:0]  V_Count,
    output logic        Pipe_enable,
    output logic        oRead_out_en,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
    output logic        LCD_HS,
    output logic        LCD_VS,
    output logic        LCD_DE,
    output logic [7:0]  LCD_R,
    output logic [7:0]  LCD_G,
    output logic [7:0]  LCD_B,
    output logic        Frame_done,
    output logic [15:0] Frame_count
);

    frame_state_t state;
    logic end_of_line, last_line, frame_point;
    logic streaming, v_active, de_next, read_next;
    int   h_pos, v_pos;

    lcd_raster_counter #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_raster (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .clock_en    (Clock_en),
        .h_count     (H_Count),
        .v_count     (V_Count),
        .end_of_line (end_of_line),
        .end_of_frame(last_line)
    );

    assign frame_point = end_of_line && last_line;
    assign streaming   = (state == RUN) || (state == STOPPING);
    assign h_pos       = int'(H_Count);
    assign v_pos       = int'(V_Count);
    assign v_active    = in_range(v_pos, V_START, V_START + V_ACTIVE - 1);
    assign de_next     = streaming && v_active
                         && in_range(h_pos, H_START, H_START + H_ACTIVE - 1);
    // The read window is the active window shifted READ_LEAD pixels earlier.
    assign read_next   = streaming && v_active
                         && in_range(h_pos, H_START - READ_LEAD,
                                     H_START + H_ACTIVE - 1 - READ_LEAD);

    // Panel outputs and the read strobe load on the edge that opens a Clock_en=1
    // cycle, so the strobe is a single-Clock pulse inside that cycle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            LCD_HS       <= 1'b1;
            LCD_VS       <= 1'b1;
            LCD_DE       <= 1'b0;
            LCD_R        <= '0;
            LCD_G        <= '0;
            LCD_B        <= '0;
            oRead_out_en <= 1'b0;
        end else if (!Clock_en) begin
            LCD_HS       <= (h_pos >= H_SYNC_W);
            LCD_VS       <= (v_pos >= V_SYNC_W);
            LCD_DE       <= de_next;
            LCD_R        <= de_next ? R_in : 8'd0;
            LCD_G        <= de_next ? G_in : 8'd0;
            LCD_B        <= de_next ? B_in : 8'd0;
            oRead_out_en <= read_next;
        end else begin
            oRead_out_en <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            Pipe_enable <= 1'b0;
            Frame_done  <= 1'b0;
            Frame_count <= '0;
        end else begin
            Frame_done <= 1'b0;
            if (frame_point && streaming) begin
                Frame_done  <= 1'b1;
                Frame_count <= Frame_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (Enable) state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (!Enable) begin
                        state <= IDLE;
                    end else if (frame_point) begin
                        state       <= RUN;
                        Pipe_enable <= 1'b1;
                    end
                end
                RUN: begin
                    if (!Enable) state <= STOPPING;
                end
                STOPPING: begin
                    if (Enable) begin
                        state <= RUN;
                    end else if (frame_point) begin
                        state       <= IDLE;
                        Pipe_enable <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_out.sv
// Self-checking bench for lcd_frame_out on a shrunken raster, compared every
// Clock against a pixel-index arithmetic model of the panel timing.
module tb_lcd_frame_out;

    localparam int HT = 20, HSW = 3, HS0 = 6, HA = 8;
    localparam int VT = 12, VSW = 2, VS0 = 3, VA = 6;
    localparam int RL = 2;
    localparam int FRAME = HT * VT;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Enable = 1'b0;
    logic [7:0]  R_in = '0, G_in = '0, B_in = '0;
    logic        Clock_en, Pipe_enable, oRead_out_en;
    logic [10:0] H_Count;
    logic [9:0]  V_Count;
    logic        LCD_HS, LCD_VS, LCD_DE, Frame_done;
    logic [7:0]  LCD_R, LCD_G, LCD_B;
    logic [15:0] Frame_count;

    lcd_frame_out #(
        .H_TOTAL(HT), .H_SYNC_W(HSW), .H_START(HS0), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC_W(VSW), .V_START(VS0), .V_ACTIVE(VA),
        .READ_LEAD(RL)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
        .Clock_en(Clock_en), .H_Count(H_Count), .V_Count(V_Count),
        .Pipe_enable(Pipe_enable), .oRead_out_en(oRead_out_en),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .LCD_HS(LCD_HS), .LCD_VS(LCD_VS), .LCD_DE(LCD_DE),
        .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
        .Frame_done(Frame_done), .Frame_count(Frame_count)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass = 0;

    // Model: k = Clock edges since reset release; pixel index = k/2.
    int          k;
    bit          strm, en_prev, hs_m, vs_m, de_m, rd_m, done_m, prev_de;
    logic [7:0]  r_m, g_m, b_m;
    logic [15:0] frames;
    int          rd_cnt, de_cnt, last_rd_k, first_rd_k;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit in_win(input int val, input int lo, input int len);
        return (val >= lo) && (val < lo + len);
    endfunction

    task automatic model_reset();
        k = 0; strm = 0; en_prev = 0;
        hs_m = 1; vs_m = 1; de_m = 0; rd_m = 0; done_m = 0; prev_de = 0;
        r_m = '0; g_m = '0; b_m = '0; frames = '0;
        rd_cnt = 0; de_cnt = 0; last_rd_k = -100; first_rd_k = -1;
    endtask

    task automatic check_reset_outputs();
        check("rst_clock_en", Clock_en, 0);
        check("rst_h_count", H_Count, 0);
        check("rst_v_count", V_Count, 0);
        check("rst_hs", LCD_HS, 1);
        check("rst_vs", LCD_VS, 1);
        check("rst_de", LCD_DE, 0);
        check("rst_rgb", {LCD_R, LCD_G, LCD_B}, 0);
        check("rst_pipe_enable", Pipe_enable, 0);
        check("rst_read_en", oRead_out_en, 0);
        check("rst_frame_done", Frame_done, 0);
        check("rst_frame_count", Frame_count, 0);
    endtask

    task automatic check_all();
        int p;
        p = k / 2;
        check("clock_en", Clock_en, k % 2);
        check("h_count", H_Count, p % HT);
        check("v_count", V_Count, (p / HT) % VT);
        check("lcd_hs", LCD_HS, hs_m);
        check("lcd_vs", LCD_VS, vs_m);
        check("lcd_de", LCD_DE, de_m);
        check("lcd_r", LCD_R, r_m);
        check("lcd_g", LCD_G, g_m);
        check("lcd_b", LCD_B, b_m);
        check("read_en", oRead_out_en, rd_m);
        check("pipe_enable", Pipe_enable, strm);
        check("frame_done", Frame_done, done_m);
        check("frame_count", Frame_count, frames);
    endtask

    task automatic tick();
        bit         en_c, act;
        logic [7:0] r_c, g_c, b_c;
        int         c, p, hm, vm;
        en_c = Enable; r_c = R_in; g_c = G_in; b_c = B_in;
        @(posedge Clock);
        #1;
        c = k; k++;
        p = c / 2; hm = p % HT; vm = (p / HT) % VT;
        done_m = 0;
        if (c % 2 == 0) begin
            act  = strm && in_win(hm, HS0, HA) && in_win(vm, VS0, VA);
            hs_m = (hm >= HSW);
            vs_m = (vm >= VSW);
            de_m = act;
            r_m  = act ? r_c : 8'd0;
            g_m  = act ? g_c : 8'd0;
            b_m  = act ? b_c : 8'd0;
            rd_m = strm && in_win(hm + RL, HS0, HA) && in_win(vm, VS0, VA);
        end else begin
            rd_m = 0;
            if (p % FRAME == FRAME - 1) begin
                check("reads_per_frame", rd_cnt, strm ? HA * VA : 0);
                check("de_clocks_per_frame", de_cnt, strm ? 2 * HA * VA : 0);
                rd_cnt = 0; de_cnt = 0;
                if (strm) begin
                    done_m = 1;
                    frames = frames + 16'd1;
                end
                // Streaming flips only when Enable held the new level across the boundary.
                if (en_prev && en_c) strm = 1;
                else if (!en_prev && !en_c) strm = 0;
            end
        end
        en_prev = en_c;
        check_all();
        if (oRead_out_en === 1'b1) begin
            if (k - last_rd_k > 2) first_rd_k = k;
            last_rd_k = k;
            rd_cnt++;
        end
        if (LCD_DE === 1'b1) de_cnt++;
        if (LCD_DE === 1'b1 && !prev_de) begin
            check("read_to_de_clocks", k - first_rd_k, 2 * RL);
            first_rd_k = -1;
        end
        prev_de = (LCD_DE === 1'b1);
        R_in = 8'($urandom); G_in = 8'($urandom); B_in = 8'($urandom);
    endtask

    task automatic run_until(input int line, input int col);
        while ((k / 2) % FRAME != line * HT + col) tick();
    endtask

    initial begin
        model_reset();
        Resetn = 1'b0;
        @(posedge Clock);
        #1;
        check_reset_outputs();
        Resetn = 1'b1;
        model_reset();

        // Two idle frames: sync only, no streaming.
        repeat (2 * FRAME * 2) tick();

        // Start request mid-frame; streaming begins at the next boundary.
        run_until(5, 10);
        Enable = 1'b1;
        repeat (3 * FRAME * 2) tick();

        // Stop request mid-frame; the frame finishes before the pipe stops.
        run_until(8, 0);
        Enable = 1'b0;
        repeat (2 * FRAME * 2 + 10) tick();

        // Restart, then drop and restore Enable inside one frame.
        Enable = 1'b1;
        repeat (2 * FRAME * 2) tick();
        run_until(4, 0);
        Enable = 1'b0;
        repeat (30) tick();
        Enable = 1'b1;
        repeat (2 * FRAME * 2) tick();

        // Random Enable levels and hold times, including boundary-straddling changes.
        repeat (40) begin
            Enable = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 400)) tick();
        end

        // Asynchronous reset in the middle of a streamed frame.
        Enable = 1'b1;
        repeat (2 * FRAME * 2) tick();
        run_until(7, 10);
        #2;
        Resetn = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge Clock);
        #1;
        check_reset_outputs();
        Resetn = 1'b1;
        model_reset();
        repeat (3 * FRAME * 2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
